reg_dump: RTL and testbench
===========================

Name: reg_dump

Overview:
Debug reader for the core register file: on a start pulse it sweeps a contiguous register range through one combinational read port and streams each (index, value) pair out over a valid/ready handshake. It sits beside the register file, driving a spare raddr port, and feeds a debug/trace sink (UART formatter, test bench monitor). It never writes the register file.

Parameters:
ADDR_W, 5, register index width
DATA_W, 32, register data width
FIRST_REG, 0, first index dumped
LAST_REG, 31, last index dumped (must be >= FIRST_REG)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin a dump
abort  input  1  cancel dump in progress
rf_raddr  output  ADDR_W  read address to register file port
rf_rdata  input  DATA_W  combinational read data for rf_raddr
out_valid  output  1  out_addr/out_data hold a beat
out_ready  input  1  sink accepts beat
out_addr  output  ADDR_W  index of current beat
out_data  output  DATA_W  value of current beat
busy  output  1  dump in progress
done  output  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (async, rst=1): state IDLE; rf_raddr, out_addr, out_data = 0; out_valid, busy, done = 0.
- All outputs registered; rf_raddr driven from internal index register.
- States: IDLE, READ, SEND.
- IDLE: busy=0. start=1 and abort=0 -> index<=FIRST_REG, rf_raddr<=FIRST_REG, go READ.
- READ (1 cycle): rf_rdata valid for rf_raddr this cycle; out_data<=rf_rdata, out_addr<=index, out_valid<=1, go SEND.
- SEND: out_valid=1, out_addr/out_data held stable until out_valid&out_ready.
  - Handshake, index==LAST_REG: out_valid<=0, done<=1 for one cycle, go IDLE.
  - Handshake, index<LAST_REG: index<=index+1, rf_raddr<=index+1, out_valid<=0, go READ.
  - No handshake: stay, nothing changes.
- Throughput: 2 cycles per register minimum; full default dump with out_ready tied high = 64 cycles start-to-done-pulse, 32 beats.
- busy=1 in READ and SEND; busy falls the cycle done pulses.
- start while busy: ignored, no restart, no effect on index.
- start in the cycle done pulses (state IDLE): accepted, new dump begins.
- abort=1 in READ or SEND: next cycle IDLE, out_valid=0, busy=0, done stays 0; a beat presented with out_ready=1 in the same cycle as abort is treated as not accepted.
- abort and start together in IDLE: abort wins, stay IDLE.
- Index x0: dumped as whatever rf_rdata returns (register file forces 0); no special case here.
- FIRST_REG==LAST_REG: single beat then done.
- Index compare on ADDR_W bits; no wrap past LAST_REG (LAST_REG=31 never increments to 0).
- Register file contents changed mid-dump: each beat reflects value sampled in its READ cycle.

Test Plan:
- Preload r14=2, r18=4, rest =index*3; start, out_ready=1 -> 32 beats in order, beat 14 data 2, beat 18 data 4, beat 0 data 0, done pulses exactly once at cycle 64, busy low after.
- out_ready toggled 1-of-3 cycles -> no beat lost/duplicated, out_data/out_addr stable while valid&!ready, 32 beats total.
- abort asserted while SEND on index 7 with out_ready=1 -> index 7 not counted, out_valid 0 next cycle, no done; restart dumps from index 0.
- start pulsed again at index 10 -> ignored, sequence continues 11..31, single done.
- rst asserted asynchronously mid-dump (index 20, off clock edge) -> outputs 0 immediately, IDLE; post-reset start gives full clean dump.
- FIRST_REG=5, LAST_REG=5 -> one beat addr 5, done one cycle after acceptance; FIRST_REG=28, LAST_REG=31 -> beats 28..31, no wrap to 0.

Source files
------------

// File: rtl/reg_dump_if.sv
// Beat stream from the register dumper to a debug/trace sink.
// valid/addr/data are held by the master until valid & ready.
interface reg_dump_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;

   modport master (output valid, addr, data, input ready);
   modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/reg_dump.sv
// Debug reader: sweeps register indices FIRST_REG..LAST_REG through one
// combinational read port and streams (index, value) beats to a sink.
module reg_dump #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   reg_dump_if.master        out,
   output logic              busy,
   output logic              done
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] SEND = 2'd2;

   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

   logic [1:0]        state;
   logic [ADDR_W-1:0] index;

   assign rf_raddr = index;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         index     <= '0;
         out.valid <= 1'b0;
         out.addr  <= '0;
         out.data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  index <= FIRST_IDX;
                  busy  <= 1'b1;
                  state <= READ;
               end
            end
            READ: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  out.data  <= rf_rdata;
                  out.addr  <= index;
                  out.valid <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               // Abort outranks a simultaneous handshake: that beat is dropped.
               if (abort) begin
                  out.valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (out.ready) begin
                  out.valid <= 1'b0;
                  if (index == LAST_IDX) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     index <= index + ADDR_W'(1);
                     state <= READ;
                  end
               end
            end
            default: begin
               out.valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_reg_dump.sv
// Randomised and directed bench for reg_dump: beats are checked against an
// expected (index, register value) sequence derived from a register file array.
module tb_reg_dump;
   logic        clk = 1'b0;
   logic        rst;
   logic        start, abort, start5, start28, no_abort;
   logic [4:0]  rf_raddr, rf_raddr5, rf_raddr28;
   logic [31:0] rf_rdata, rf_rdata5, rf_rdata28;
   logic        busy, done, busy5, done5, busy28, done28;
   logic [31:0] rf [32];
   int          total = 0;
   int          bad = 0;

   reg_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();
   reg_dump_if #(.ADDR_W(5), .DATA_W(32)) bus5 ();
   reg_dump_if #(.ADDR_W(5), .DATA_W(32)) bus28 ();

   assign rf_rdata   = rf[rf_raddr];
   assign rf_rdata5  = rf[rf_raddr5];
   assign rf_rdata28 = rf[rf_raddr28];

   always #5 clk = ~clk;

   reg_dump #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out(bus.master),
      .busy(busy), .done(done));

   reg_dump #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(5), .LAST_REG(5)) dut5 (
      .clk(clk), .rst(rst), .start(start5), .abort(no_abort),
      .rf_raddr(rf_raddr5), .rf_rdata(rf_rdata5), .out(bus5.master),
      .busy(busy5), .done(done5));

   reg_dump #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(28), .LAST_REG(31)) dut28 (
      .clk(clk), .rst(rst), .start(start28), .abort(no_abort),
      .rf_raddr(rf_raddr28), .rf_rdata(rf_rdata28), .out(bus28.master),
      .busy(busy28), .done(done28));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Runs one full dump from index 0 after the start edge; ready_mode 0=always,
   // 1=one cycle in three, 2=random. Optionally re-pulses start at restart_at
   // and rewrites not-yet-read registers while a beat is pending.
   task automatic collect(input int ready_mode, input int restart_at, input bit mutate,
                          output int done_at);
      int          ticks, beats, dones, phase;
      logic        pv, pr;
      logic [4:0]  pa;
      logic [31:0] pd;
      ticks = 0; beats = 0; dones = 0; phase = 0; done_at = -1;
      pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;
      while (ticks < 1000 && !(done_at >= 0 && ticks >= done_at + 3)) begin
         case (ready_mode)
            0:       bus.ready = 1'b1;
            1:       bus.ready = (phase % 3 == 0);
            default: bus.ready = 1'($urandom_range(0, 1));
         endcase
         phase++;
         start = bus.valid && restart_at >= 0 && int'(bus.addr) == restart_at;
         if (pv && !pr && bus.valid) begin
            check("hold_addr", 64'(bus.addr), 64'(pa));
            check("hold_data", 64'(bus.data), 64'(pd));
         end
         if (bus.valid && bus.ready) begin
            check("beat_addr", 64'(bus.addr), 64'(beats));
            check("beat_data", 64'(bus.data), 64'(rf[beats % 32]));
            beats++;
         end
         if (mutate && bus.valid && bus.addr < 5'd31)
            rf[$urandom_range(int'(bus.addr) + 1, 31)] = $urandom;
         pv = bus.valid; pr = bus.ready; pa = bus.addr; pd = bus.data;
         tick();
         ticks++;
         if (done) begin
            dones++;
            if (done_at < 0) done_at = ticks;
         end
      end
      start = 1'b0;
      bus.ready = 1'b0;
      check("beat_count", 64'(beats), 64'd32);
      check("done_count", 64'(dones), 64'd1);
      check("busy_after", 64'(busy), 64'd0);
   endtask

   initial begin
      int done_at, acc, n;
      rst = 1'b1; start = 1'b0; abort = 1'b0; start5 = 1'b0; start28 = 1'b0;
      no_abort = 1'b0;
      bus.ready = 1'b0; bus5.ready = 1'b1; bus28.ready = 1'b1;
      for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
      rf[14] = 32'd2;
      rf[18] = 32'd4;

      #2;
      check("rst_raddr", 64'(rf_raddr), 64'd0);
      check("rst_valid", 64'(bus.valid), 64'd0);
      check("rst_addr", 64'(bus.addr), 64'd0);
      check("rst_data", 64'(bus.data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      #6 rst = 1'b0;
      tick();

      // Full dump with the sink always ready: done 64 cycles after start.
      pulse_start();
      check("busy_started", 64'(busy), 64'd1);
      collect(0, -1, 1'b0, done_at);
      check("done_cycle", 64'(done_at), 64'd64);

      // Sink ready one cycle in three, registers changing ahead of the sweep.
      fill_random();
      pulse_start();
      collect(1, -1, 1'b1, done_at);

      // Abort on the index 7 beat with ready high: beat 7 is dropped.
      fill_random();
      bus.ready = 1'b1;
      pulse_start();
      acc = 0; n = 0;
      while (!(bus.valid && bus.addr == 5'd7) && n < 100) begin
         if (bus.valid) acc++;
         tick();
         n++;
      end
      check("pre_abort_beats", 64'(acc), 64'd7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_valid", 64'(bus.valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      tick();
      check("abort_no_late_done", 64'(done), 64'd0);

      // Abort and start together in idle: abort wins.
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      check("abort_start_busy", 64'(busy), 64'd0);
      tick();
      check("abort_start_valid", 64'(bus.valid), 64'd0);

      pulse_start();
      collect(2, -1, 1'b0, done_at);

      // Start re-pulsed at index 10 must not restart or perturb the sweep.
      fill_random();
      pulse_start();
      collect(0, 10, 1'b0, done_at);
      check("restart_ignored_cycle", 64'(done_at), 64'd64);

      // Asynchronous reset off the clock edge in the middle of a dump.
      pulse_start();
      bus.ready = 1'b1;
      n = 0;
      while (!(bus.valid && bus.addr == 5'd20) && n < 100) begin
         tick();
         n++;
      end
      check("reached_20", 64'(bus.addr), 64'd20);
      #3 rst = 1'b1;
      #1;
      check("arst_raddr", 64'(rf_raddr), 64'd0);
      check("arst_valid", 64'(bus.valid), 64'd0);
      check("arst_addr", 64'(bus.addr), 64'd0);
      check("arst_data", 64'(bus.data), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      #1 rst = 1'b0;
      bus.ready = 1'b0;
      tick();
      check("arst_idle", 64'(busy), 64'd0);
      fill_random();
      pulse_start();
      collect(0, -1, 1'b0, done_at);
      check("arst_done_cycle", 64'(done_at), 64'd64);

      // Narrow ranges: single register 5 and top range 28..31 without wrap.
      fill_random();
      start5 = 1'b1; start28 = 1'b1;
      tick();
      start5 = 1'b0; start28 = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         check("r5_valid", 64'(bus5.valid), 64'(t == 1));
         check("r5_done", 64'(done5), 64'(t == 2));
         if (t == 1) begin
            check("r5_addr", 64'(bus5.addr), 64'd5);
            check("r5_data", 64'(bus5.data), 64'(rf[5]));
         end
         check("r28_valid", 64'(bus28.valid), 64'(t <= 7 && (t % 2) == 1));
         check("r28_done", 64'(done28), 64'(t == 8));
         check("r28_busy", 64'(busy28), 64'(t < 8));
         if (bus28.valid) begin
            check("r28_addr", 64'(bus28.addr), 64'(28 + (t - 1) / 2));
            check("r28_data", 64'(bus28.data), 64'(rf[28 + (t - 1) / 2]));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
